// File: rtl/mips_alu_md_pkg.sv
// rtl/mips_alu_md_pkg.sv - opcode and mul/div FSM encodings shared by the ALU slice
package mips_alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'd0;
  localparam logic [3:0] ALU_OR    = 4'd1;
  localparam logic [3:0] ALU_ADD   = 4'd2;
  localparam logic [3:0] ALU_XOR   = 4'd3;
  localparam logic [3:0] ALU_SLL   = 4'd4;
  localparam logic [3:0] ALU_SRL   = 4'd5;
  localparam logic [3:0] ALU_SUB   = 4'd6;
  localparam logic [3:0] ALU_SLT   = 4'd7;
  localparam logic [3:0] ALU_SLTU  = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_MULT  = 4'd10;
  localparam logic [3:0] ALU_MULTU = 4'd11;
  localparam logic [3:0] ALU_NOR   = 4'd12;
  localparam logic [3:0] ALU_DIV   = 4'd13;
  localparam logic [3:0] ALU_DIVU  = 4'd14;
  localparam logic [3:0] ALU_MFHL  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FIXUP = 2'd2
  } md_state_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/mips_alu_md_if.sv
// rtl/mips_alu_md_if.sv - EX-stage request/result bundle between pipeline and ALU
interface mips_alu_md_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out_valid;
  logic [WIDTH-1:0] alu_out;
  logic             zero;
  logic             cout;
  logic             ovf;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output in_valid, alu_ctrl, in1, in2,
    input  in_ready, out_valid, alu_out, zero, cout, ovf, hi, lo
  );

  modport slave (
    input  in_valid, alu_ctrl, in1, in2,
    output in_ready, out_valid, alu_out, zero, cout, ovf, hi, lo
  );
endinterface

// File: rtl/mips_alu_md_muldiv_iter.sv
// rtl/mips_alu_md_muldiv_iter.sv - radix-2 multiply / restoring divide engine
module mips_muldiv_iter
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             idle_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  md_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q, step_acc, prod;
  logic [WIDTH-1:0]   divisor_q, dividend_q;
  logic               div_q, neg_res_q, neg_rem_q, div0_q;
  logic               a_neg, b_neg, div_ge;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH-1:0]   div_trial, quo, rem;

  assign a_neg = is_signed_i & a_i[WIDTH-1];
  assign b_neg = is_signed_i & b_i[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_BUSY;
      ST_BUSY:  if (cnt_q == CW'(1)) state_d = ST_FIXUP;
      ST_FIXUP: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idle_o = (state_q == ST_IDLE);
    done_o = (state_q == ST_BUSY) && (cnt_q == CW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      divisor_q  <= '0;
      dividend_q <= '0;
      div_q      <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div0_q     <= 1'b0;
    end else if (start_i && (state_q == ST_IDLE)) begin
      cnt_q      <= CW'(WIDTH);
      acc_q      <= {{WIDTH{1'b0}}, (a_neg ? -a_i : a_i)};
      divisor_q  <= b_neg ? -b_i : b_i;
      dividend_q <= a_i;
      div_q      <= is_div_i;
      neg_res_q  <= a_neg ^ b_neg;
      neg_rem_q  <= a_neg;
      div0_q     <= is_div_i && (b_i == '0);
    end else if (state_q == ST_BUSY) begin
      cnt_q <= cnt_q - CW'(1);
      acc_q <= step_acc;
    end
  end

  // The sign fixup is applied to the final step's value, so hi/lo land in the
  // top's registers on the edge that enters FIXUP and are presented during it.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, divisor_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, divisor_q};
    div_trial = div_shift[WIDTH-1:0] - divisor_q;
    if (div_q) step_acc = {(div_ge ? div_trial : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    else       step_acc = {mul_sum, acc_q[WIDTH-1:1]};
    prod = neg_res_q ? -step_acc : step_acc;
    quo  = step_acc[WIDTH-1:0];
    rem  = step_acc[2*WIDTH-1:WIDTH];
    if (!div_q) begin
      hi_o = prod[2*WIDTH-1:WIDTH];
      lo_o = prod[WIDTH-1:0];
    end else if (div0_q) begin
      hi_o = dividend_q;
      lo_o = '1;
    end else begin
      hi_o = neg_rem_q ? -rem : rem;
      lo_o = neg_res_q ? -quo : quo;
    end
  end

endmodule

// File: rtl/mips_alu_md.sv
// rtl/mips_alu_md.sv - registered EX-stage ALU with iterative mul/div into HI/LO
module mips_alu_md
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic          clk,
  input logic          rst_n,
  mips_alu_md_if.slave bus
);

  logic             accept, md_start, md_idle, md_done, add_ovf, sub_ovf;
  logic [3:0]       op;
  logic [WIDTH-1:0] a, b, res, diff, md_hi, md_lo;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;

  logic             out_valid_q, out_valid_d, zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d, hi_q, hi_d, lo_q, lo_d;

  assign op       = bus.alu_ctrl;
  assign a        = bus.in1;
  assign b        = bus.in2;
  assign shamt    = a[SHW-1:0];
  assign accept   = bus.in_valid && md_idle;
  assign md_start = accept && is_muldiv(op);

  mips_muldiv_iter #(.WIDTH(WIDTH)) u_md (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (md_start),
    .is_div_i    ((op == ALU_DIV) || (op == ALU_DIVU)),
    .is_signed_i ((op == ALU_MULT) || (op == ALU_DIV)),
    .a_i         (a),
    .b_i         (b),
    .idle_o      (md_idle),
    .done_o      (md_done),
    .hi_o        (md_hi),
    .lo_o        (md_lo)
  );

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    diff    = a - b;
    add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    case (op)
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_ADD:  res = sum[WIDTH-1:0];
      ALU_XOR:  res = a ^ b;
      ALU_SLL:  res = b << shamt;
      ALU_SRL:  res = b >> shamt;
      ALU_SUB:  res = diff;
      ALU_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SRA:  res = $signed(b) >>> shamt;
      ALU_NOR:  res = ~(a | b);
      ALU_MFHL: res = b[0] ? hi_q : lo_q;
      default:  res = '0;
    endcase
  end

  always_comb begin
    out_valid_d = 1'b0;
    alu_out_d   = alu_out_q;
    zero_d      = zero_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    if (md_done) begin
      out_valid_d = 1'b1;
      alu_out_d   = md_lo;
      zero_d      = (md_lo == '0);
      cout_d      = 1'b0;
      ovf_d       = 1'b0;
      hi_d        = md_hi;
      lo_d        = md_lo;
    end else if (accept && !is_muldiv(op)) begin
      out_valid_d = 1'b1;
      alu_out_d   = res;
      zero_d      = (res == '0);
      cout_d      = (op == ALU_ADD) && sum[WIDTH];
      ovf_d       = ((op == ALU_ADD) && add_ovf) || ((op == ALU_SUB) && sub_ovf);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      zero_q      <= 1'b1;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      zero_q      <= zero_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign bus.in_ready  = md_idle;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_out   = alu_out_q;
  assign bus.zero      = zero_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule

// File: tb/tb_mips_alu_md.sv
// tb/tb_mips_alu_md.sv - scoreboard bench for the registered ALU with iterative mul/div
module tb_mips_alu_md;
  import mips_alu_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic         zero;
    logic         cout;
    logic         ovf;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  res_t exp_q[$];
  res_t obs_q[$];
  int   obs_cyc_q[$];

  mips_alu_md_if #(.WIDTH(W)) bus ();
  mips_alu_md #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      obs_q.push_back('{res: bus.alu_out, zero: bus.zero, cout: bus.cout, ovf: bus.ovf,
                        hi: bus.hi, lo: bus.lo});
      obs_cyc_q.push_back(cyc);
    end
  end

  function automatic res_t mk(input logic [W-1:0] r, input logic c, input logic v);
    return '{res: r, zero: (r == '0), cout: c, ovf: v, hi: m_hi, lo: m_lo};
  endfunction

  function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s, sx;
    logic [W-1:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; s = '0; sx = '0;
    case (op)
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_NOR: r = ~(a | b);
      ALU_SLL: r = b << a[4:0];
      ALU_SRL: r = b >> a[4:0];
      ALU_ADD: begin
        s = {1'b0, a} + {1'b0, b}; sx = {a[W-1], a} + {b[W-1], b};
        r = s[W-1:0]; c = s[W]; v = sx[W] ^ sx[W-1];
      end
      default: begin
        sx = {a[W-1], a} - {b[W-1], b};
        r = sx[W-1:0]; v = sx[W] ^ sx[W-1];
      end
    endcase
    return mk(r, c, v);
  endfunction

  task automatic push_md(input logic [W-1:0] h, input logic [W-1:0] l);
    m_hi = h;
    m_lo = l;
    exp_q.push_back('{res: l, zero: (l == '0), cout: 1'b0, ovf: 1'b0, hi: h, lo: l});
  endtask

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.alu_ctrl = op; bus.in1 = a; bus.in2 = b;
    while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
    acc = cyc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic get_result(output res_t e, output res_t o, output int oc, output bit got);
    int n;
    n = 0;
    while (obs_q.size() == 0 && n < 100) begin @(negedge clk); #1; n++; end
    got = (obs_q.size() != 0) && (exp_q.size() != 0);
    if (got) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); oc = obs_cyc_q.pop_front();
    end else begin
      e = '0; o = '0; oc = -1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.zero, bus.cout, bus.ovf} !== 5'b10100) begin
      failures++;
      $display("FAIL reset_flags: got rdy/vld/z/c/v=%b want 10100",
               {bus.in_ready, bus.out_valid, bus.zero, bus.cout, bus.ovf});
    end
    checks++;
    if ({bus.alu_out, bus.hi, bus.lo} !== '0) begin
      failures++;
      $display("FAIL reset_regs: got out=%h hi=%h lo=%h want all 0", bus.alu_out, bus.hi, bus.lo);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add_sub();
    res_t e, o; int oc; bit got; int acc[4];
    exp_q.push_back(mk(32'h8000_0000, 1'b0, 1'b1)); send(ALU_ADD, 32'h7FFF_FFFF, 32'h1, acc[0]);
    exp_q.push_back(mk(32'h0000_0000, 1'b1, 1'b0)); send(ALU_ADD, 32'hFFFF_FFFF, 32'h1, acc[1]);
    exp_q.push_back(mk(32'h7FFF_FFFF, 1'b0, 1'b1)); send(ALU_SUB, 32'h8000_0000, 32'h1, acc[2]);
    exp_q.push_back(mk(32'hFFFF_FFFE, 1'b0, 1'b0)); send(ALU_SUB, 32'h5, 32'h7, acc[3]);
    for (int i = 0; i < 4; i++) begin
      get_result(e, o, oc, got);
      checks++;
      if (!got || o !== e || oc != acc[i] + 1) begin
        failures++;
        $display("FAIL add_sub[%0d]: got %h at cyc %0d, want %h at cyc %0d", i, o, oc, e, acc[i] + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t e, o; int oc; bit got; int acc[3];
    exp_q.push_back(mk(32'h1, 1'b0, 1'b0));         send(ALU_SLT,  32'hFFFF_FFFF, 32'h1, acc[0]);
    exp_q.push_back(mk(32'h0, 1'b0, 1'b0));         send(ALU_SLTU, 32'hFFFF_FFFF, 32'h1, acc[1]);
    exp_q.push_back(mk(32'hF800_0000, 1'b0, 1'b0)); send(ALU_SRA,  32'h4, 32'h8000_0000, acc[2]);
    for (int i = 0; i < 3; i++) begin
      get_result(e, o, oc, got);
      checks++;
      if (!got || o !== e || oc != acc[i] + 1 || (i > 0 && acc[i] != acc[i-1] + 1)) begin
        failures++;
        $display("FAIL back_to_back[%0d]: got %h at cyc %0d, want %h at cyc %0d", i, o, oc, e, acc[i] + 1);
      end
    end
  endtask

  task automatic test_random_ops();
    res_t e, o; int oc; bit got; int acc[12];
    logic [3:0] pool[8] = '{ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB};
    logic [3:0] op; logic [W-1:0] a, b;
    for (int i = 0; i < 12; i++) begin
      op = pool[$urandom_range(0, 7)]; a = $urandom; b = $urandom;
      exp_q.push_back(model(op, a, b));
      send(op, a, b, acc[i]);
    end
    for (int i = 0; i < 12; i++) begin
      get_result(e, o, oc, got);
      checks++;
      if (!got || o !== e || oc != acc[i] + 1) begin
        failures++;
        $display("FAIL random_op[%0d]: got %h at cyc %0d, want %h at cyc %0d", i, o, oc, e, acc[i] + 1);
      end
    end
  endtask

  task automatic test_mult_hold();
    res_t e, o; int oc; bit got; int acc, acc2, n;
    push_md(32'hFFFF_FFFF, 32'hFFFF_FFEB);
    send(ALU_MULT, 32'hFFFF_FFFD, 32'h7, acc);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.alu_ctrl = ALU_ADD; bus.in1 = 32'h2; bus.in2 = 32'h3;
    n = 0;
    while (!bus.in_ready && n < 100) begin n++; @(negedge clk); end
    checks++;
    if (n != W + 1) begin
      failures++;
      $display("FAIL mult_busy_len: in_ready low for %0d cycles, want %0d", n, W + 1);
    end
    exp_q.push_back(mk(32'h5, 1'b0, 1'b0));
    acc2 = cyc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    get_result(e, o, oc, got);
    checks++;
    if (!got || o !== e || oc != acc + W + 1) begin
      failures++;
      $display("FAIL mult_result: got %h at cyc %0d, want %h at cyc %0d", o, oc, e, acc + W + 1);
    end
    get_result(e, o, oc, got);
    checks++;
    if (!got || o !== e || oc != acc2 + 1 || acc2 != acc + W + 2) begin
      failures++;
      $display("FAIL held_add: got %h accepted %0d, want %h accepted %0d", o, acc2, e, acc + W + 2);
    end
  endtask

  task automatic test_mfhl();
    res_t e, o; int oc; bit got; int acc[3];
    push_md(32'h1, 32'h0);                   send(ALU_MULTU, 32'h0001_0000, 32'h0001_0000, acc[0]);
    exp_q.push_back(mk(32'h1, 1'b0, 1'b0)); send(ALU_MFHL, $urandom, 32'h1, acc[1]);
    exp_q.push_back(mk(32'h0, 1'b0, 1'b0)); send(ALU_MFHL, $urandom, 32'h0, acc[2]);
    for (int i = 0; i < 3; i++) begin
      get_result(e, o, oc, got);
      checks++;
      if (!got || o !== e || (i > 0 && acc[i] != acc[0] + W + 1 + i)) begin
        failures++;
        $display("FAIL mfhl[%0d]: got %h accepted %0d, want %h", i, o, acc[i], e);
      end
    end
  endtask

  task automatic test_div();
    res_t e, o; int oc; bit got; int acc[3];
    push_md(32'hFFFF_FFFF, 32'hFFFF_FFFD); send(ALU_DIV,  32'hFFFF_FFF9, 32'h2, acc[0]);
    push_md(32'h0000_0007, 32'hFFFF_FFFF); send(ALU_DIVU, 32'h7, 32'h0, acc[1]);
    push_md(32'h0000_0000, 32'h8000_0000); send(ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, acc[2]);
    for (int i = 0; i < 3; i++) begin
      get_result(e, o, oc, got);
      checks++;
      if (!got || o !== e || oc != acc[i] + W + 1) begin
        failures++;
        $display("FAIL div[%0d]: got %h at cyc %0d, want %h at cyc %0d", i, o, oc, e, acc[i] + W + 1);
      end
    end
  endtask

  task automatic test_reset_mid_mult();
    res_t e, o; int oc; bit got; int acc;
    send(ALU_MULT, 32'h5, 32'h6, acc);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.zero} !== 3'b101 || {bus.hi, bus.lo, bus.alu_out} !== '0) begin
      failures++;
      $display("FAIL reset_mid_mult: rdy/vld/z=%b hi=%h lo=%h out=%h, want 101 and zeros",
               {bus.in_ready, bus.out_valid, bus.zero}, bus.hi, bus.lo, bus.alu_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL aborted_mult_result: got %0d results, want 0", obs_q.size());
      obs_q.delete(); obs_cyc_q.delete();
    end
    exp_q.push_back(mk(32'h2, 1'b0, 1'b0));
    send(ALU_ADD, 32'h1, 32'h1, acc);
    get_result(e, o, oc, got);
    checks++;
    if (!got || o !== e) begin
      failures++;
      $display("FAIL post_reset_add: got %h, want %h", o, e);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.alu_ctrl = '0;
    bus.in1      = '0;
    bus.in2      = '0;
    test_reset();
    test_add_sub();
    test_back_to_back();
    test_random_ops();
    test_mult_hold();
    test_mfhl();
    test_div();
    test_reset_mid_mult();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
